// File: rtl/addsub_pkg.sv
// Shared constants and FSM state type for the nibble-serial add/subtract unit.
package addsub_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_addsub.sv
// One 4-bit add/subtract slice: x + (y ^ {4{m}}) + cin, built from full-adder cells.
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                m,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] w_y;
  logic [NIBBLE_W:0]   w_c;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
      assign w_y[gi]     = y[gi] ^ m;
      assign sum[gi]     = x[gi] ^ w_y[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (x[gi] & w_y[gi]) | (w_c[gi] & (x[gi] ^ w_y[gi]));
    end
  endgenerate

  assign cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_addsub.sv
// W-bit add/subtract computed one nibble per clock, LSB nibble first,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  input  logic                         m,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  s,
  output logic                         c,
  output logic                         v,
  output logic                         z
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_t r_state;
  state_t w_state_next;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_a;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_b;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_s;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] w_s_upd;
  logic [IDXW-1:0]                  r_idx;
  logic                             r_m;
  logic                             r_carry;
  logic                             r_c;
  logic                             r_v;
  logic                             r_z;

  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic                w_last;
  logic                w_bx_top;

  nibble_addsub u_slice (
    .x    (r_a[r_idx]),
    .y    (r_b[r_idx]),
    .m    (r_m),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_last   = (r_idx == LAST_IDX);
  assign w_bx_top = r_b[NIBBLES-1][NIBBLE_W-1] ^ (r_m == MODE_SUB);

  // Result image with the current nibble merged in, so z sees the final nibble too.
  always_comb begin
    w_s_upd        = r_s;
    w_s_upd[r_idx] = w_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_m     <= 1'b0;
      r_carry <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_m     <= m;
            r_carry <= m;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_s     <= w_s_upd;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_c <= w_cout;
            r_v <= (r_a[NIBBLES-1][NIBBLE_W-1] == w_bx_top) &&
                   (w_sum[NIBBLE_W-1] != r_a[NIBBLES-1][NIBBLE_W-1]);
            r_z <= (w_s_upd == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign s = r_s;
  assign c = r_c;
  assign v = r_v;
  assign z = r_z;

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
Multi-word add/subtract unit that runs a W-bit operation one 4-bit nibble per clock, least-significant nibble first.
Each nibble goes through a single 4-bit add/sub slice, with carry chained in a register between cycles.
Operands arrive and results leave over valid/ready handshakes, so the block sits between an operand source and a result consumer.
Trades latency for area compared with a W-bit ripple adder.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand request valid
in_ready  output  1  block can accept a request
a  input  W  operand A
b  input  W  operand B
m  input  1  mode: 0 = add (A+B), 1 = subtract (A-B)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
s  output  W  result
c  output  1  add: carry out; subtract: 1 = no borrow (A >= B unsigned)
v  output  1  two's-complement signed overflow
z  output  1  s == 0

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). While rst is high at an edge, all state is cleared.
- Reset values: state IDLE, s=0, c=0, v=0, z=0, out_valid=0, nibble index=0, carry reg=0. in_ready=0 in any cycle where rst is high, 1 in IDLE otherwise.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch a, b, m; set carry reg=m and index=0; go to RUN.
  - Captured operands are independent of later input changes.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge computes nibble i: a[i] + (b[i] XOR {4{m}}) + carry reg.
  - The 4-bit sum is written into s[4i+3:4i]; carry reg takes the slice carry out; index increments.
  - On the edge processing nibble NIBBLES-1:
    - c = final carry out.
    - v = (A[W-1] == Bx[W-1]) AND (S[W-1] != A[W-1]), where Bx is B after the XOR with m.
    - z = all W result bits zero, including the nibble just written.
    - Go to DONE.
- DONE:
  - out_valid=1.
  - s, c, v, z held stable until the edge where out_valid and out_ready are both 1; then go to IDLE.
  - out_valid is 0 from that edge on.
  - in_ready=0 throughout DONE; no overlap of accept and deliver.
- Latency: request accepted at edge E0 → out_valid first high after edge E0+NIBBLES.
- Throughput: one operation per NIBBLES+2 cycles when out_ready is held high.
- s holds the previous result until overwritten nibble-by-nibble during RUN. s is only meaningful while out_valid=1.
- Wrap-around: the result is modulo 2^W. Carry out of the top nibble is reported only via c, never extends s.
- in_valid outside IDLE is ignored, and nothing is queued.
- out_ready outside DONE is ignored.
- Reset mid-RUN or mid-DONE: the operation is aborted and the result discarded. The next cycle is IDLE with reset values, and no out_valid pulse is produced.
- NIBBLES=1: RUN lasts one cycle, and behaviour matches a registered 4-bit add/sub.

Decomposition:
- Package addsub_pkg holds:
  - NIBBLE_W=4
  - MODE_ADD=0, MODE_SUB=1
  - FSM state enum (IDLE, RUN, DONE)
- Sub-module nibble_addsub, purely combinational:
  - Inputs: 4-bit x, 4-bit y, m, cin.
  - Outputs: 4-bit sum, cout.
  - y is XORed with m internally; built from four full-adder cells.
- Top holds FSM, operand registers, index counter, carry reg, result/flag registers.

Test Plan:
All scenarios use NIBBLES=4.
- Add 0x1234 + 0x4321, m=0 → s=0x5555, c=0, v=0, z=0. out_valid rises exactly 4 cycles after acceptance.
- Add 0xFFFF + 0x0001 → s=0x0000, c=1, v=0, z=1.
- Subtract 0x0005 - 0x0007 → s=0xFFFE, c=0, v=0, z=0. Subtract 0x8000 - 0x0001 → s=0x7FFF, c=1, v=1.
- Add 0x7FFF + 0x0001 → s=0x8000, c=0, v=1. Subtract 0x1234 - 0x1234 → s=0, c=1, z=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, driving in_valid=1 with new operands.
  - s, c, v, z and out_valid must stay stable, in_ready=0, and the new request is not captured.
  - After the out_ready handshake, in_ready=1 next cycle and the new op completes correctly.
- Assert rst for one cycle during RUN (after 2 nibbles).
  - Next cycle: IDLE, out_valid=0, s=0, flags=0.
  - A following 0x00FF + 0x0001 yields s=0x0100, c=0.
